// File: rtl/bounce_pkg.sv
// Shared definitions for the contact-bounce emulator: FSM encoding, LFSR
// feedback taps and the default LFSR seed.
package bounce_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ON     = 2'd1,
        ST_OFF    = 2'd2,
        ST_SETTLE = 2'd3
    } bounce_state_e;

    // Galois taps for x^16 + x^14 + x^13 + x^11 + 1, right-shifting form.
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        logic [15:0] nxt;
        nxt = {1'b0, cur[15:1]};
        if (cur[0]) begin
            nxt = nxt ^ LFSR_TAPS;
        end else begin
            nxt = nxt;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bounce_gen_lfsr16.sv
// Free-running 16-bit Galois LFSR; reusable pseudo-random source for
// self-test stimulus generators.
module lfsr16
    import bounce_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] state_o
);

    // An all-zero seed would lock the register, so fall back to the default.
    localparam logic [15:0] SEED_SAFE = (SEED == 16'h0000) ? DEFAULT_SEED : SEED;

    logic [15:0] state_q;
    logic [15:0] state_d;

    // Next state: one Galois shift per cycle.
    always_comb begin
        state_d = lfsr_step(state_q);
    end

    // State register with synchronous reset to the seed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEED_SAFE;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/bounce_gen.sv
// Switch-bounce emulator: on start, alternates noisy between target and its
// complement for n bounce pairs, holds target for a settle period, pulses done.
module bounce_gen
    import bounce_pkg::*;
#(
    parameter bit          RANDOM     = 1'b0,
    parameter int unsigned DWELL_FIX  = 3,
    parameter int unsigned DWELL_BITS = 4,
    parameter int unsigned SETTLE     = 16,
    parameter int unsigned NB_W       = 3,
    parameter logic [15:0] SEED       = DEFAULT_SEED
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            target,
    input  logic [NB_W-1:0] bounces,
    output logic            noisy,
    output logic            busy,
    output logic            done
);

    localparam int FIX_W = $clog2(DWELL_FIX + 1);
    localparam int DW_W  = ((DWELL_BITS + 1) > FIX_W) ? (DWELL_BITS + 1) : FIX_W;
    localparam int ST_W  = ($clog2(SETTLE + 1) < 1) ? 1 : $clog2(SETTLE + 1);

    localparam logic [DW_W-1:0] DW_ONE      = DW_W'(1);
    localparam logic [DW_W-1:0] DW_ZERO     = {DW_W{1'b0}};
    localparam logic [DW_W-1:0] DW_FIXED    = DW_W'(DWELL_FIX);
    localparam logic [ST_W-1:0] ST_ONE      = ST_W'(1);
    localparam logic [ST_W-1:0] ST_ZERO     = {ST_W{1'b0}};
    localparam logic [ST_W-1:0] SETTLE_LOAD = ST_W'(SETTLE);
    localparam logic [NB_W-1:0] NB_ONE      = NB_W'(1);
    localparam logic [NB_W-1:0] NB_ZERO     = {NB_W{1'b0}};

    bounce_state_e   state_q,  state_d;
    logic            noisy_q,  noisy_d;
    logic            busy_q,   busy_d;
    logic            done_q,   done_d;
    logic            tgt_q,    tgt_d;
    logic [NB_W-1:0] n_q,      n_d;
    logic [DW_W-1:0] dwell_q,  dwell_d;
    logic [ST_W-1:0] settle_q, settle_d;

    logic [15:0]     lfsr_s;
    logic            lfsr_unused_s;
    logic [DW_W-1:0] dwell_load_s;

    lfsr16 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .state_o (lfsr_s)
    );

    assign lfsr_unused_s = ^lfsr_s;

    // Dwell length sampled at the start of every ON/OFF phase.
    always_comb begin
        if (RANDOM) begin
            dwell_load_s = {{(DW_W - DWELL_BITS){1'b0}}, lfsr_s[DWELL_BITS-1:0]} + DW_ONE;
        end else begin
            dwell_load_s = DW_FIXED;
        end
    end

    // Next-state and next-output logic for the bounce sequencer.
    always_comb begin
        state_d  = state_q;
        noisy_d  = noisy_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        tgt_d    = tgt_q;
        n_d      = n_q;
        dwell_d  = dwell_q;
        settle_d = settle_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    tgt_d   = target;
                    n_d     = bounces;
                    noisy_d = target;
                    busy_d  = 1'b1;
                    if (bounces != NB_ZERO) begin
                        state_d = ST_ON;
                        dwell_d = dwell_load_s;
                    end else begin
                        state_d  = ST_SETTLE;
                        settle_d = SETTLE_LOAD;
                    end
                end else begin
                    busy_d = 1'b0;
                end
            end

            ST_ON: begin
                if (dwell_q == DW_ONE) begin
                    state_d = ST_OFF;
                    noisy_d = ~tgt_q;
                    dwell_d = dwell_load_s;
                end else begin
                    dwell_d = dwell_q - DW_ONE;
                end
            end

            ST_OFF: begin
                if (dwell_q == DW_ONE) begin
                    n_d     = n_q - NB_ONE;
                    noisy_d = tgt_q;
                    // The last OFF phase hands straight over to the settle hold.
                    if (n_q == NB_ONE) begin
                        state_d  = ST_SETTLE;
                        dwell_d  = DW_ZERO;
                        settle_d = SETTLE_LOAD;
                    end else begin
                        state_d = ST_ON;
                        dwell_d = dwell_load_s;
                    end
                end else begin
                    dwell_d = dwell_q - DW_ONE;
                end
            end

            ST_SETTLE: begin
                if (settle_q == ST_ONE) begin
                    state_d  = ST_IDLE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    settle_d = ST_ZERO;
                end else begin
                    settle_d = settle_q - ST_ONE;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                busy_d   = 1'b0;
                n_d      = NB_ZERO;
                dwell_d  = DW_ZERO;
                settle_d = ST_ZERO;
            end
        endcase
    end

    // Sequencer registers, including the registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            noisy_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            tgt_q    <= 1'b0;
            n_q      <= NB_ZERO;
            dwell_q  <= DW_ZERO;
            settle_q <= ST_ZERO;
        end else begin
            state_q  <= state_d;
            noisy_q  <= noisy_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            tgt_q    <= tgt_d;
            n_q      <= n_d;
            dwell_q  <= dwell_d;
            settle_q <= settle_d;
        end
    end

    assign noisy = noisy_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_bounce_gen.sv
// Directed self-checking bench for bounce_gen: fixed-dwell waveforms, busy
// guard, reset abort, random-dwell runs and a debouncer loopback model.
module tb_bounce_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_f, start_f, target_f, noisy_f, busy_f, done_f;
    logic [2:0] bounces_f;
    logic       rst_r, start_r, target_r, noisy_r, busy_r, done_r;
    logic [2:0] bounces_r;

    bounce_gen #(
        .RANDOM(1'b0), .DWELL_FIX(3), .DWELL_BITS(4), .SETTLE(16), .NB_W(3), .SEED(16'hACE1)
    ) u_fix (
        .clk(clk), .rst(rst_f), .start(start_f), .target(target_f), .bounces(bounces_f),
        .noisy(noisy_f), .busy(busy_f), .done(done_f)
    );

    bounce_gen #(
        .RANDOM(1'b1), .DWELL_FIX(3), .DWELL_BITS(4), .SETTLE(16), .NB_W(3), .SEED(16'hACE1)
    ) u_rnd (
        .clk(clk), .rst(rst_r), .start(start_r), .target(target_r), .bounces(bounces_r),
        .noisy(noisy_r), .busy(busy_r), .done(done_r)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [15:0] tb_step(input logic [15:0] s);
        logic [15:0] r;
        r = {1'b0, s[15:1]};
        if (s[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    // Reference LFSR for the random instance; m_prev is the value seen at the last edge.
    logic [15:0] m_lfsr, m_prev;
    always @(posedge clk) begin
        m_prev <= m_lfsr;
        m_lfsr <= rst_r ? 16'hACE1 : tb_step(m_lfsr);
    end

    bit mon_en = 1'b0;
    int lfsr_bad = 0;
    int lfsr_zero = 0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (u_rnd.lfsr_s !== m_lfsr) lfsr_bad++;
            if (u_rnd.lfsr_s == 16'h0000) lfsr_zero++;
        end
    end

    // Behavioural debouncer: clean follows noisy after 4 consecutive differing samples.
    logic       db_clean = 1'b0;
    logic [2:0] db_cnt = 3'd0;
    int         rises = 0;
    int         falls = 0;
    always @(posedge clk) begin
        if (rst_f) begin
            db_clean <= 1'b0;
            db_cnt   <= 3'd0;
        end else if (noisy_f !== db_clean) begin
            if (db_cnt == 3'd3) begin
                db_clean <= noisy_f;
                db_cnt   <= 3'd0;
                if (noisy_f) rises <= rises + 1;
                else         falls <= falls + 1;
            end else begin
                db_cnt <= db_cnt + 3'd1;
            end
        end else begin
            db_cnt <= 3'd0;
        end
    end

    // Target 1, two bounce pairs, dwell 3, settle 16; optional busy-time start and chained start.
    task automatic run_pattern(input bit guard, input bit chain);
        logic exp_n;
        start_f = 1'b1; target_f = 1'b1; bounces_f = 3'd2;
        for (int k = 1; k <= 29; k++) begin
            cyc();
            if (k == 1) start_f = 1'b0;
            exp_n = (k <= 12) ? (((k - 1) / 3) % 2 == 0) : 1'b1;
            check_eq($sformatf("pat noisy@T+%0d", k), noisy_f, exp_n);
            check_eq($sformatf("pat busy@T+%0d", k), busy_f, (k <= 28));
            check_eq($sformatf("pat done@T+%0d", k), done_f, (k == 29));
            if (guard && k == 5) begin start_f = 1'b1; target_f = 1'b0; bounces_f = 3'd5; end
            if (guard && k == 6) start_f = 1'b0;
            if (chain && k == 29) begin start_f = 1'b1; target_f = 1'b0; bounces_f = 3'd0; end
        end
        if (chain) begin
            for (int k = 30; k <= 46; k++) begin
                cyc();
                if (k == 30) start_f = 1'b0;
                check_eq($sformatf("chain noisy@T+%0d", k), noisy_f, 1'b0);
                check_eq($sformatf("chain busy@T+%0d", k), busy_f, (k < 46));
                check_eq($sformatf("chain done@T+%0d", k), done_f, (k == 46));
            end
        end
    endtask

    logic wave_q[$];

    // One random-mode run of 7 bounce pairs; phase lengths checked against the reference LFSR.
    task automatic rand_run(input bit t, input bit rec,
                            output int bad, output int nedge, output int settle_len);
        logic [4:0] exp_len;
        logic       last;
        int         cur;
        bad = 0; nedge = 0;
        start_r = 1'b1; target_r = t; bounces_r = 3'd7;
        cyc();
        start_r = 1'b0;
        if (busy_r !== 1'b1 || noisy_r !== t) bad++;
        if (rec) wave_q.push_back(noisy_r);
        exp_len = 5'd1 + {1'b0, m_prev[3:0]};
        cur = 1;
        last = noisy_r;
        for (int i = 0; i < 1000 && done_r !== 1'b1; i++) begin
            cyc();
            if (rec) wave_q.push_back(noisy_r);
            if (done_r !== 1'b1) begin
                if (noisy_r !== last) begin
                    if (cur != int'(exp_len) || cur < 1 || cur > 16) bad++;
                    nedge++;
                    exp_len = 5'd1 + {1'b0, m_prev[3:0]};
                    cur = 1;
                    last = noisy_r;
                end else begin
                    cur++;
                end
            end
        end
        if (done_r !== 1'b1) bad++;
        settle_len = cur;
    endtask

    task automatic rand_reset();
        rst_r = 1'b1;
        cyc();
        cyc();
        rst_r = 1'b0;
    endtask

    int   bad, nedge, slen, done_seen, diffs;
    logic wave_a[$];

    initial begin
        rst_f = 1'b1; start_f = 1'b0; target_f = 1'b0; bounces_f = 3'd0;
        rst_r = 1'b1; start_r = 1'b0; target_r = 1'b0; bounces_r = 3'd0;
        @(negedge clk);
        cyc();
        check_eq("rst noisy", noisy_f, 1'b0);
        check_eq("rst busy", busy_f, 1'b0);
        check_eq("rst done", done_f, 1'b0);
        check_eq("rst lfsr", u_fix.lfsr_s, 16'hACE1);
        rst_f = 1'b0; rst_r = 1'b0;
        mon_en = 1'b1;
        cyc();
        check_eq("lfsr step1", u_fix.lfsr_s, 16'hE270);

        run_pattern(1'b0, 1'b0);
        check_eq("loop rises a", rises, 1);
        check_eq("loop falls a", falls, 0);

        // Zero bounces from a high level: output never moves.
        start_f = 1'b1; target_f = 1'b1; bounces_f = 3'd0;
        for (int k = 1; k <= 17; k++) begin
            cyc();
            if (k == 1) start_f = 1'b0;
            check_eq($sformatf("zero noisy@T+%0d", k), noisy_f, 1'b1);
            check_eq($sformatf("zero busy@T+%0d", k), busy_f, (k <= 16));
            check_eq($sformatf("zero done@T+%0d", k), done_f, (k == 17));
        end

        run_pattern(1'b1, 1'b1);
        check_eq("loop rises b", rises, 1);
        check_eq("loop falls b", falls, 1);

        // Reset in the middle of the bounce train.
        start_f = 1'b1; target_f = 1'b1; bounces_f = 3'd2;
        for (int k = 1; k <= 7; k++) begin
            cyc();
            if (k == 1) start_f = 1'b0;
            check_eq($sformatf("rmid noisy@T+%0d", k), noisy_f, (((k - 1) / 3) % 2 == 0));
        end
        rst_f = 1'b1;
        cyc();
        check_eq("rmid noisy@T+8", noisy_f, 1'b0);
        check_eq("rmid busy@T+8", busy_f, 1'b0);
        check_eq("rmid done@T+8", done_f, 1'b0);
        check_eq("rmid lfsr seed", u_fix.lfsr_s, 16'hACE1);
        rst_f = 1'b0;
        cyc();
        check_eq("rmid lfsr step1", u_fix.lfsr_s, 16'hE270);
        cyc();
        check_eq("rmid lfsr step2", u_fix.lfsr_s, 16'h7138);
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            cyc();
            if (done_f === 1'b1 || busy_f === 1'b1) done_seen++;
        end
        check_eq("rmid no done", done_seen, 0);

        // Fresh run after the abort: 3 pairs, done 35 cycles after start.
        start_f = 1'b1; target_f = 1'b1; bounces_f = 3'd3;
        for (int k = 1; k <= 35; k++) begin
            cyc();
            if (k == 1) start_f = 1'b0;
            check_eq($sformatf("n3 noisy@T+%0d", k), noisy_f,
                     (k <= 18) ? (((k - 1) / 3) % 2 == 0) : 1'b1);
            check_eq($sformatf("n3 done@T+%0d", k), done_f, (k == 35));
        end
        check_eq("loop rises c", rises, 2);
        check_eq("loop falls c", falls, 1);

        // Random mode: identical resets give identical waveforms.
        rand_reset();
        wave_q.delete();
        rand_run(1'b1, 1'b1, bad, nedge, slen);
        wave_a = wave_q;
        wave_q.delete();
        rand_reset();
        rand_run(1'b1, 1'b1, bad, nedge, slen);
        check_eq("rnd repeat len", wave_q.size(), wave_a.size());
        diffs = 0;
        for (int i = 0; i < wave_a.size() && i < wave_q.size(); i++) begin
            if (wave_a[i] !== wave_q[i]) diffs++;
        end
        check_eq("rnd repeat wave", diffs, 0);

        for (int r = 0; r < 100; r++) begin
            rand_run(r[0], 1'b0, bad, nedge, slen);
            check_eq($sformatf("rnd run%0d phases", r), bad, 0);
            check_eq($sformatf("rnd run%0d edges", r), nedge, 14);
            check_eq($sformatf("rnd run%0d settle", r), slen, 16);
        end
        check_eq("rnd lfsr track", lfsr_bad, 0);
        check_eq("rnd lfsr zero", lfsr_zero, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bounce_gen.md
# bounce_gen

Synthesizable switch-bounce emulator: the transmit end of the debouncer's `noisy` input. On command it drives a contact-bounce waveform of a requested length toward a target level, holds the level for a settle period, and then signals completion. It sits in front of the debouncer for on-board self-test and closed-loop simulation, replacing a physical push-button.

## Interface
- `RANDOM`, 0 — 0: every dwell phase lasts `DWELL_FIX` cycles; 1: dwell comes from the LFSR.
- `DWELL_FIX`, 3 — fixed dwell in cycles, ≥1.
- `DWELL_BITS`, 4 — random dwell range is 1..2^DWELL_BITS cycles.
- `SETTLE`, 16 — cycles `noisy` holds the target after the last bounce, ≥1.
- `NB_W`, 3 — width of the bounce-count input.
- `SEED`, 16'hACE1 — LFSR reset value; must be nonzero.

Ports:
- `clk`  in  1  — single clock.
- `rst`  in  1  — synchronous, active-high reset.
- `start`  in  1  — request a transition; sampled only while `busy`=0.
- `target`  in  1  — final level for `noisy`; captured with `start`.
- `bounces`  in  NB_W  — number of bounce pairs n; captured with `start`.
- `noisy`  out  1  — registered emulated contact output, feeds the debouncer `noisy` input.
- `busy`  out  1  — high while a transition is in progress.
- `done`  out  1  — one-cycle pulse when the transition completes.

## Operation
- Reset values: `noisy`=0, `busy`=0, `done`=0, state IDLE, LFSR=SEED, all counters 0.
- **IDLE:** `noisy` holds its last value.
  - `start`=1 captures `target`→tgt and `bounces`→n.
  - n>0 → ON. n=0 → SETTLE.
- **ON:** `noisy`=tgt for dwell cycles, then → OFF.
- **OFF:** `noisy`=~tgt for dwell cycles.
  - Decrement n. If n=0 → SETTLE, otherwise → ON.
- **SETTLE:** `noisy`=tgt for `SETTLE` cycles, then → IDLE with `done`=1 for one cycle.
- Dwell value:
  - Latched on entry to each ON/OFF phase.
  - `RANDOM`=0 → `DWELL_FIX`.
  - `RANDOM`=1 → 1 + lfsr[DWELL_BITS-1:0]. Width is DWELL_BITS+1, so no overflow.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Advances every cycle regardless of state.
  - Never reaches zero.
- If tgt equals the current `noisy` level, the first ON phase produces no edge. This is legal; the waveform is still ON/OFF alternation.
- `start` while `busy`=1: ignored, with no effect on captured values.
- `start` in the same cycle as the `done` pulse: accepted, because the state is IDLE.
- `rst` mid-operation: next cycle returns to reset values. Any partial waveform is abandoned and no `done` is issued.

## Timing
- `start` is sampled at edge T (state IDLE).
- From cycle T+1:
  - `busy`=1.
  - `noisy` takes its first phase value: tgt if n>0; tgt for SETTLE when n=0.
- `RANDOM`=0:
  - Bounce phases occupy cycles T+1 … T+2·n·D, with D=`DWELL_FIX`.
  - Settle occupies T+2nD+1 … T+2nD+SETTLE.
  - At T+2nD+SETTLE+1: `done`=1, `busy`=0, `noisy`=tgt (held).
- Total latency from start to done: 2nD+SETTLE+1 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `bounce_pkg`:
  - State encoding {IDLE, ON, OFF, SETTLE}.
  - LFSR tap constant 16'hB400.
  - Default `SEED`.
- One sub-module: `lfsr16` (clk, rst, seed parameter, 16-bit state output), reusable for other self-test stimulus.
- FSM, dwell counter, bounce counter and settle counter live in `bounce_gen`.

## Test plan
- **Fixed pattern:** `RANDOM`=0, `DWELL_FIX`=3, `SETTLE`=16; `start` at T with `target`=1, `bounces`=2.
  - `noisy` reads 1,1,1,0,0,0,1,1,1,0,0,0 over T+1..T+12, then 1 over T+13..T+28.
  - `done` pulses at T+29; `busy` is high T+1..T+28.
- **Zero bounces:** `noisy`=1, `target`=1, `bounces`=0.
  - `noisy` never changes; `done` at T+17.
- **Busy guard:** `start` with `target`=0 asserted at T+5 during the fixed-pattern run.
  - Waveform and `done` time are identical to scenario 1.
  - A `start` coincident with `done` launches a new run whose first phase is at T+30.
- **Reset mid-bounce:** `rst` at T+7 of scenario 1.
  - At T+8: `noisy`=0, `busy`=0, no `done`.
  - The LFSR sequence after reset matches the post-power-on sequence.
- **Random mode:** `RANDOM`=1, `DWELL_BITS`=4, 100 runs with `bounces`=7.
  - Every phase length is in 1..16.
  - LFSR never reads 0.
  - Two runs after identical resets produce identical waveforms.
- **Loopback:** `noisy` drives the debouncer (`rst`, `clk`, `noisy`, `clean`).
  - Each completed 0→1 run produces exactly one rising edge on `clean`, and each 1→0 run exactly one falling edge.
  - `SETTLE` is chosen greater than the debouncer count.
